// File: rtl/riscv_mstage_lsu.sv
// riscv_mstage_lsu: memory-stage load unit with channel routing, data extension, timeout and flush.
module riscv_mstage_lsu #(
    parameter int XLEN    = 64,
    parameter int NCH     = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                i_riscv_lsu_clk,
    input  logic                i_riscv_lsu_rst_n,
    input  logic                i_riscv_lsu_req_valid,
    output logic                o_riscv_lsu_req_ready,
    input  logic [XLEN-1:0]     i_riscv_lsu_addr,
    input  logic [2:0]          i_riscv_lsu_memext,
    input  logic [2:0]          i_riscv_lsu_chsel,
    input  logic                i_riscv_lsu_flush,
    output logic [NCH-1:0]      o_riscv_lsu_ch_req,
    input  logic [NCH-1:0]      i_riscv_lsu_ch_rvalid,
    input  logic [NCH*XLEN-1:0] i_riscv_lsu_ch_rdata,
    output logic                o_riscv_lsu_busy,
    output logic                o_riscv_lsu_valid,
    output logic [XLEN-1:0]     o_riscv_lsu_memload,
    output logic [1:0]          o_riscv_lsu_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [2:0] off_q, ext_q;
    logic [NCH-1:0] ch_req_q;
    logic [7:0] cnt;
    logic [XLEN-1:0] memload_q, rd, sh, ext_data;
    logic [1:0] err_q;
    logic accept, bad_ch, misal, hit, tmo, unused_addr;
    assign unused_addr = ^i_riscv_lsu_addr[XLEN-1:3];
    assign accept = state == IDLE && i_riscv_lsu_req_valid && !i_riscv_lsu_flush;
    assign bad_ch = 32'(i_riscv_lsu_chsel) >= NCH;
    assign misal = (i_riscv_lsu_memext[1:0] == 2'd1 && i_riscv_lsu_addr[0]) ||
                   (i_riscv_lsu_memext[1:0] == 2'd2 && i_riscv_lsu_addr[1:0] != 2'd0) ||
                   (i_riscv_lsu_memext[1:0] == 2'd3 && i_riscv_lsu_addr[2:0] != 3'd0);
    // ch_req_q is one-hot on the selected channel during WAIT, so it masks both rvalid and rdata
    assign hit = state == WAIT && |(i_riscv_lsu_ch_rvalid & ch_req_q);
    assign tmo = state == WAIT && !hit && cnt == 8'(TIMEOUT);
    always_comb begin
        rd = '0;
        for (int k = 0; k < NCH; k++) rd = rd | (ch_req_q[k] ? i_riscv_lsu_ch_rdata[k*XLEN +: XLEN] : '0);
    end
    assign sh = rd >> {off_q, 3'b000};
    assign ext_data = ext_q[1:0] == 2'd0 ? {{(XLEN-8){sh[7] & ~ext_q[2]}}, sh[7:0]} :
                      ext_q[1:0] == 2'd1 ? {{(XLEN-16){sh[15] & ~ext_q[2]}}, sh[15:0]} :
                      ext_q[1:0] == 2'd2 ? {{(XLEN-32){sh[31] & ~ext_q[2]}}, sh[31:0]} : sh;
    always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rst_n) begin
        if (!i_riscv_lsu_rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = (state != IDLE && i_riscv_lsu_flush) ? IDLE :
                   state == IDLE ? (accept ? ((bad_ch || misal) ? RESP : WAIT) : IDLE) :
                   state == WAIT ? ((hit || tmo) ? RESP : WAIT) : IDLE;
    end
    always_comb begin
        o_riscv_lsu_req_ready = state == IDLE && !i_riscv_lsu_flush;
        o_riscv_lsu_busy      = state != IDLE;
        o_riscv_lsu_valid     = state == RESP && !i_riscv_lsu_flush;
        o_riscv_lsu_ch_req    = ch_req_q;
        o_riscv_lsu_memload   = memload_q;
        o_riscv_lsu_err       = err_q;
    end
    always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rst_n) begin
        if (!i_riscv_lsu_rst_n) begin
            off_q     <= '0;
            ext_q     <= '0;
            ch_req_q  <= '0;
            cnt       <= '0;
            memload_q <= '0;
            err_q     <= '0;
        end else if (accept) begin
            off_q    <= i_riscv_lsu_addr[2:0];
            ext_q    <= i_riscv_lsu_memext;
            cnt      <= '0;
            ch_req_q <= (bad_ch || misal) ? '0 : NCH'(1) << i_riscv_lsu_chsel;
            if (bad_ch || misal) begin
                memload_q <= '0;
                err_q     <= bad_ch ? 2'b11 : 2'b01;
            end
        end else if (state == WAIT) begin
            if (i_riscv_lsu_flush) begin
                ch_req_q <= '0;
            end else if (hit) begin
                ch_req_q  <= '0;
                memload_q <= ext_data;
                err_q     <= 2'b00;
            end else if (tmo) begin
                ch_req_q  <= '0;
                memload_q <= '0;
                err_q     <= 2'b10;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_mstage_lsu.sv
// tb_riscv_mstage_lsu: scoreboard bench with random loads against a byte-level reference model.
module tb_riscv_mstage_lsu;
    localparam int XLEN = 64, NCH = 4, TIMEOUT = 16;
    logic clk = 0, rst_n = 0;
    logic req_valid = 0, flush = 0;
    logic [63:0] addr = '0;
    logic [2:0] memext = '0, chsel = '0;
    logic [NCH-1:0] rvalid = '0;
    logic [NCH*XLEN-1:0] rdata = '0;
    logic req_ready, busy, valid;
    logic [NCH-1:0] ch_req;
    logic [63:0] memload;
    logic [1:0] err;

    riscv_mstage_lsu #(.XLEN(XLEN), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .i_riscv_lsu_clk(clk), .i_riscv_lsu_rst_n(rst_n),
        .i_riscv_lsu_req_valid(req_valid), .o_riscv_lsu_req_ready(req_ready),
        .i_riscv_lsu_addr(addr), .i_riscv_lsu_memext(memext), .i_riscv_lsu_chsel(chsel),
        .i_riscv_lsu_flush(flush), .o_riscv_lsu_ch_req(ch_req),
        .i_riscv_lsu_ch_rvalid(rvalid), .i_riscv_lsu_ch_rdata(rdata),
        .o_riscv_lsu_busy(busy), .o_riscv_lsu_valid(valid),
        .o_riscv_lsu_memload(memload), .o_riscv_lsu_err(err)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] data; logic [1:0] err; int cyc; } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] exp_err(input logic [63:0] a, input logic [2:0] mx, input logic [2:0] cs);
        int sz = 1 << mx[1:0];
        if (int'(cs) >= NCH) return 2'b11;
        if (int'(a[2:0]) % sz != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [63:0] exp_data(input logic [63:0] a, input logic [2:0] mx, input logic [63:0] dw);
        int sz = 1 << mx[1:0];
        logic [63:0] v = dw >> (8 * int'(a[2:0]));
        logic [63:0] mask;
        if (sz == 8) return v;
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v = v & mask;
        if (!mx[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=1 expected=0 cycle=%0d", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("memload", memload, mon_e.data);
                chk("err", 64'(err), 64'(mon_e.err));
                chk("latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // d: WAIT cycle index of selected rvalid (>TIMEOUT means never), fl: WAIT cycle of flush (-1 none), fr: flush in RESP
    task automatic do_load(input logic [63:0] a, input logic [2:0] mx, input logic [2:0] cs,
                           input logic [63:0] dw, input int d, input int fl, input bit fr);
        int acc;
        logic [1:0] e;
        @(posedge clk); #1;
        req_valid = 1; addr = a; memext = mx; chsel = cs;
        @(negedge clk);
        acc = cyc;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 0; addr = {$urandom, $urandom}; memext = 3'($urandom); chsel = 3'($urandom);
        e = exp_err(a, mx, cs);
        if (e != 2'b00) begin
            q.push_back('{64'd0, e, acc + 1});
            @(negedge clk);
            chk("ch_req_err", 64'(ch_req), 64'd0);
            chk("req_ready_resp", 64'(req_ready), 64'd0);
            return;
        end
        for (int k = 0; k <= TIMEOUT; k++) begin
            rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rvalid = NCH'($urandom) & ~(NCH'(1) << cs);
            if (k == d || k == fl) begin
                rvalid[cs] = 1'b1;
                rdata[int'(cs)*XLEN +: XLEN] = dw;
            end
            if (k == fl) flush = 1;
            else if (k == d) begin
                if (!fr) q.push_back('{exp_data(a, mx, dw), 2'b00, acc + 2 + d});
            end else if (k == TIMEOUT) begin
                if (!fr) q.push_back('{64'd0, 2'b10, acc + 2 + TIMEOUT});
            end
            @(negedge clk);
            if (k == 0) chk("ch_req_wait", 64'(ch_req), 64'(NCH'(1) << cs));
            chk("busy_wait", 64'(busy), 64'd1);
            if (k == fl || k == d || k == TIMEOUT) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rvalid = '0;
        if (flush) begin
            flush = 0;
            rvalid[cs] = 1'b1;
            rdata[int'(cs)*XLEN +: XLEN] = dw;
            @(negedge clk);
            chk("busy_after_flush", 64'(busy), 64'd0);
            chk("ch_req_after_flush", 64'(ch_req), 64'd0);
            @(posedge clk); #1;
            rvalid = '0;
        end else begin
            flush = fr;
            @(negedge clk);
            chk("ch_req_resp", 64'(ch_req), 64'd0);
            chk("req_ready_resp", 64'(req_ready), 64'd0);
            if (fr) chk("valid_flushed_resp", 64'(valid), 64'd0);
            @(posedge clk); #1;
            flush = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [2:0] mx, cs;
        int sz, d, fl;
        bit fr;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_ch_req", 64'(ch_req), 64'd0);
        chk("rst_memload", memload, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        do_load(64'h1003, 3'b000, 3'd0, 64'h0000_0000_8000_0000, 0, -1, 0);
        do_load(64'h2004, 3'b110, 3'd2, 64'h8765_4321_DEAD_BEEF, 1, -1, 0);
        do_load(64'h3001, 3'b001, 3'd1, 64'h0, 0, -1, 0);
        do_load(64'h4000, 3'b011, 3'd3, 64'h1122_3344_5566_7788, 99, -1, 0);
        do_load(64'h5006, 3'b001, 3'd1, 64'h8001_0000_0000_0000, TIMEOUT, -1, 0);
        do_load(64'h6000, 3'b010, 3'd0, 64'hFFFF_FFFF_7FFF_FFFF, 2, 2, 0);
        do_load(64'h7002, 3'b101, 3'd3, 64'h0000_0000_ABCD_0000, 1, -1, 1);
        @(posedge clk); #1;
        req_valid = 1; flush = 1; addr = 64'h0; memext = 3'b011; chsel = 3'd0;
        @(negedge clk);
        chk("flush_idle_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        req_valid = 0; flush = 0;
        @(negedge clk);
        chk("flush_idle_busy", 64'(busy), 64'd0);
        do_load(64'h8000, 3'b000, 3'd5, 64'h0, 0, -1, 0);
        do_load(64'h9005, 3'b100, 3'd1, 64'h00F0_0000_0000_0000, 0, -1, 0);
        @(posedge clk); #1;
        req_valid = 1; addr = 64'hA000; memext = 3'b011; chsel = 3'd1;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #3;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_ch_req", 64'(ch_req), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_memload", memload, 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 80; i++) begin
            mx = 3'($urandom);
            sz = 1 << mx[1:0];
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'((int'(a[2:0]) / sz) * sz);
            cs = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, NCH - 1)) : 3'($urandom_range(NCH, 7));
            d = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, TIMEOUT);
            fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
            fr = ($urandom_range(0, 9) == 0);
            do_load(a, mx, cs, {$urandom, $urandom}, d, fl, fr);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
